// File: rtl/mem_mp.sv
// Multi-ported register-file memory with per-entry valid bits, byte enables,
// optional write-to-read forwarding and optional registered read outputs.
module mem_mp #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int READ_PORTS   = 2,
    parameter int WRITE_PORTS  = 2,
    parameter int READ_LATENCY = 0,
    parameter int BYPASS_EN    = 0,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BL          = WIDTH / 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   clear,
    input  logic [READ_PORTS-1:0]                  re,
    input  logic [READ_PORTS-1:0][AW-1:0]          raddr,
    output logic [READ_PORTS-1:0][WIDTH-1:0]       rdata,
    output logic [READ_PORTS-1:0]                  rvalid,
    input  logic [WRITE_PORTS-1:0]                 we,
    input  logic [WRITE_PORTS-1:0][AW-1:0]         waddr,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]      wdata,
    input  logic [WRITE_PORTS-1:0][BL-1:0]         wbe
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]                  r_mem [DEPTH];
    logic [DEPTH-1:0]                  r_valid;
    logic [WRITE_PORTS-1:0]            w_wok;
    logic [READ_PORTS-1:0][WIDTH-1:0]  w_ldata;
    logic [READ_PORTS-1:0]             w_lvalid;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    always_comb begin
        w_wok = '0;
        for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            w_wok[p] = we[p] && in_range(waddr[p]);
        end
    end

    // Forwarding walks write ports in ascending order so the highest port wins per byte.
    always_comb begin
        w_ldata  = '0;
        w_lvalid = '0;
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            if (in_range(raddr[i])) begin
                w_ldata[i]  = r_mem[raddr[i]];
                w_lvalid[i] = r_valid[raddr[i]];
                if (BYPASS_EN != 0) begin
                    for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                        if (w_wok[p] && (waddr[p] == raddr[i])) begin
                            w_lvalid[i] = 1'b1;
                            for (int unsigned b = 0; b < BL; b++) begin
                                if (wbe[p][b]) begin
                                    w_ldata[i][8*b +: 8] = wdata[p][8*b +: 8];
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Clear is issued before the writes so same-cycle written entries end valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                r_mem[a] <= '0;
            end
            r_valid <= '0;
        end else begin
            if (clear) begin
                r_valid <= '0;
            end
            for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                if (w_wok[p]) begin
                    r_valid[waddr[p]] <= 1'b1;
                    for (int unsigned b = 0; b < BL; b++) begin
                        if (wbe[p][b]) begin
                            r_mem[waddr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb
            always_comb begin
                rdata  = '0;
                rvalid = '0;
                for (int unsigned i = 0; i < READ_PORTS; i++) begin
                    if (re[i]) begin
                        rdata[i]  = w_ldata[i];
                        rvalid[i] = w_lvalid[i];
                    end
                end
            end
        end else begin : g_reg
            logic [READ_PORTS-1:0][WIDTH-1:0] r_rdata;
            logic [READ_PORTS-1:0]            r_rvalid;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_rdata  <= '0;
                    r_rvalid <= '0;
                end else begin
                    for (int unsigned i = 0; i < READ_PORTS; i++) begin
                        r_rdata[i]  <= re[i] ? w_ldata[i] : '0;
                        r_rvalid[i] <= re[i] & w_lvalid[i];
                    end
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end
    endgenerate

endmodule

// File: tb/tb_mem_mp.sv
// Bench for mem_mp: four configurations share one stimulus stream and are
// compared against an array-based reference model of the memory.
module tb_mem_mp;

    logic                  clock;
    logic                  reset;
    logic                  clear;
    logic [1:0]            re;
    logic [1:0][4:0]       raddr;
    logic [1:0]            we;
    logic [1:0][4:0]       waddr;
    logic [1:0][31:0]      wdata;
    logic [1:0][3:0]       wbe;

    logic [1:0][31:0]      rd [4];
    logic [1:0]            rv [4];

    int errors;
    int checks;

    // instance k: 0 default, 1 bypass comb, 2 registered, 3 registered+bypass depth 20
    int dep [4] = '{32, 32, 32, 20};
    int byp [4] = '{0, 1, 0, 1};
    int lat [4] = '{0, 0, 1, 1};

    logic [31:0] m_mem [4][32];
    logic        m_val [4][32];
    logic [31:0] exp_d [4][2];
    logic        exp_v [4][2];

    mem_mp u_dflt (
        .clock(clock), .reset(reset), .clear(clear), .re(re), .raddr(raddr),
        .rdata(rd[0]), .rvalid(rv[0]), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe)
    );
    mem_mp #(.READ_LATENCY(0), .BYPASS_EN(1)) u_byp (
        .clock(clock), .reset(reset), .clear(clear), .re(re), .raddr(raddr),
        .rdata(rd[1]), .rvalid(rv[1]), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe)
    );
    mem_mp #(.READ_LATENCY(1), .BYPASS_EN(0)) u_reg (
        .clock(clock), .reset(reset), .clear(clear), .re(re), .raddr(raddr),
        .rdata(rd[2]), .rvalid(rv[2]), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe)
    );
    mem_mp #(.DEPTH(20), .READ_LATENCY(1), .BYPASS_EN(1)) u_regbyp (
        .clock(clock), .reset(reset), .clear(clear), .re(re), .raddr(raddr),
        .rdata(rd[3]), .rvalid(rv[3]), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    function automatic void lookup(input int k, input int i, output logic [31:0] d, output logic v);
        int a;
        a = int'(raddr[i]);
        d = '0;
        v = 1'b0;
        if (a < dep[k]) begin
            d = m_mem[k][a];
            v = m_val[k][a];
            if (byp[k] != 0) begin
                for (int p = 0; p < 2; p++) begin
                    if (we[p] && int'(waddr[p]) == a) begin
                        d = (d & ~bmask(wbe[p])) | (wdata[p] & bmask(wbe[p]));
                        v = 1'b1;
                    end
                end
            end
        end
        if (!re[i]) begin
            d = '0;
            v = 1'b0;
        end
    endfunction

    function automatic void model_update();
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                for (int a = 0; a < 32; a++) begin
                    m_mem[k][a] = '0;
                    m_val[k][a] = 1'b0;
                end
            end else begin
                if (clear) for (int a = 0; a < 32; a++) m_val[k][a] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (we[p] && int'(waddr[p]) < dep[k]) begin
                        m_val[k][waddr[p]] = 1'b1;
                        m_mem[k][waddr[p]] = (m_mem[k][waddr[p]] & ~bmask(wbe[p])) | (wdata[p] & bmask(wbe[p]));
                    end
                end
            end
        end
    endfunction

    // One clock: combinational instances checked before the edge, registered ones after.
    task automatic cycle();
        logic [31:0] d;
        logic        v;
        #1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                lookup(k, i, d, v);
                if (reset) begin
                    exp_d[k][i] = '0;
                    exp_v[k][i] = 1'b0;
                end else begin
                    exp_d[k][i] = d;
                    exp_v[k][i] = v;
                end
                if (lat[k] == 0) begin
                    chk($sformatf("comb i%0d p%0d data", k, i), rd[k][i], d);
                    chk($sformatf("comb i%0d p%0d valid", k, i), {31'b0, rv[k][i]}, {31'b0, v});
                end
            end
        end
        @(posedge clock);
        model_update();
        #1;
        for (int k = 0; k < 4; k++) begin
            if (lat[k] != 0) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("reg i%0d p%0d data", k, i), rd[k][i], exp_d[k][i]);
                    chk($sformatf("reg i%0d p%0d valid", k, i), {31'b0, rv[k][i]}, {31'b0, exp_v[k][i]});
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 1'b0; clear = 1'b0; re = '0; raddr = '0;
        we = '0; waddr = '0; wdata = '0; wbe = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 32; a++) begin
                m_mem[k][a] = 'x;
                m_val[k][a] = 1'bx;
            end
        idle();
        reset = 1'b1;
        @(negedge clock);
        cycle();
        reset = 1'b1; re = 2'b11; raddr[0] = 5'd0; raddr[1] = 5'd31;
        cycle();
        idle();
        cycle();
        chk("post-reset reg data", rd[2][0], 32'h0);

        // basic write then read
        we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hAABBCCDD; wbe[0] = 4'hF;
        cycle();
        idle(); re[0] = 1'b1; raddr[0] = 5'd5;
        cycle();
        chk("wr-rd data", rd[0][0], 32'hAABBCCDD);
        chk("wr-rd valid", {31'b0, rv[0][0]}, 32'd1);

        // same-address write from both ports
        idle();
        we = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd3;
        wdata[0] = 32'h11111111; wbe[0] = 4'hF; wdata[1] = 32'h22222222; wbe[1] = 4'h3;
        cycle();
        idle(); re[1] = 1'b1; raddr[1] = 5'd3;
        cycle();
        chk("port priority", rd[0][1], 32'h11112222);

        // forwarding of a partial write into the same-cycle lookup
        idle();
        we[0] = 1'b1; waddr[0] = 5'd7; wdata[0] = 32'h12345678; wbe[0] = 4'h1;
        re[0] = 1'b1; raddr[0] = 5'd7;
        #1;
        chk("bypass data", rd[1][0], 32'h00000078);
        chk("bypass valid", {31'b0, rv[1][0]}, 32'd1);
        chk("no-bypass valid", {31'b0, rv[0][0]}, 32'd0);
        cycle();

        // registered read collision
        idle();
        we[0] = 1'b1; waddr[0] = 5'd2; wdata[0] = 32'hA; wbe[0] = 4'hF;
        cycle();
        wdata[0] = 32'hB; re[0] = 1'b1; raddr[0] = 5'd2;
        cycle();
        chk("reg collision old", rd[2][0], 32'hA);
        chk("reg+byp collision new", rd[3][0], 32'hB);
        idle(); re[0] = 1'b1; raddr[0] = 5'd2;
        cycle();
        chk("reg reread", rd[2][0], 32'hB);

        // clear with concurrent write
        idle();
        we = 2'b11; waddr[0] = 5'd1; wdata[0] = 32'hC0FFEE01; wbe[0] = 4'hF;
        waddr[1] = 5'd4; wdata[1] = 32'h44444444; wbe[1] = 4'hF;
        cycle();
        idle(); clear = 1'b1; we[1] = 1'b1; waddr[1] = 5'd4; wdata[1] = 32'h55555555; wbe[1] = 4'h0;
        cycle();
        idle(); re = 2'b11; raddr[0] = 5'd1; raddr[1] = 5'd4;
        #1;
        chk("clear data kept", rd[0][0], 32'hC0FFEE01);
        chk("clear valid", {31'b0, rv[0][0]}, 32'd0);
        chk("clear+write valid", {31'b0, rv[0][1]}, 32'd1);
        chk("wbe0 data kept", rd[0][1], 32'h44444444);
        cycle();

        // address beyond the non-power-of-two depth
        idle();
        we[0] = 1'b1; waddr[0] = 5'd25; wdata[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
        cycle();
        idle(); re[0] = 1'b1; raddr[0] = 5'd25;
        cycle();
        chk("oob read data", rd[3][0], 32'h0);
        chk("in-range read data", rd[2][0], 32'hDEADBEEF);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            clear = ($urandom_range(0, 15) == 0);
            re    = 2'($urandom);
            we    = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                raddr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                waddr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                wdata[p] = $urandom;
                wbe[p]   = 4'($urandom);
            end
            cycle();
        end

        // reset with a concurrent write
        idle();
        we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h99999999; wbe[0] = 4'hF;
        cycle();
        idle(); reset = 1'b1; we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h77777777; wbe[0] = 4'hF;
        cycle();
        idle(); re = 2'b11; raddr[0] = 5'd9; raddr[1] = 5'd9;
        cycle();
        chk("reset abandons write data", rd[0][0], 32'h0);
        chk("reset abandons write valid", {31'b0, rv[0][1]}, 32'd0);
        chk("reset reg data", rd[2][1], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_mp.md
MEM_MP -- requirements
Module: mem_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter READ_PORTS, default 2, number of independent read ports.
REQ-004 SHALL have parameter WRITE_PORTS, default 2, number of independent write ports.
REQ-005 SHALL have parameter READ_LATENCY, default 0, read latency: 0 = combinational, 1 = registered; other values illegal.
REQ-006 SHALL have parameter BYPASS_EN, default 0, write-to-read forwarding enable: 0 = off, 1 = on.
REQ-007 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port clear  input  1  flash-invalidate all entry valid bits; data is retained.
REQ-010 SHALL have port re  input  [READ_PORTS]  per-port read enable.
REQ-011 SHALL have port raddr  input  [READ_PORTS][AW]  per-port read address.
REQ-012 SHALL have port rdata  output  [READ_PORTS][WIDTH]  per-port read data.
REQ-013 SHALL have port rvalid  output  [READ_PORTS]  entry-valid flag accompanying rdata.
REQ-014 SHALL have port we  input  [WRITE_PORTS]  per-port write enable.
REQ-015 SHALL have port waddr  input  [WRITE_PORTS][AW]  per-port write address.
REQ-016 SHALL have port wdata  input  [WRITE_PORTS][WIDTH]  per-port write data.
REQ-017 SHALL have port wbe  input  [WRITE_PORTS][WIDTH/8]  per-port byte enables; bit b covers bits [8b+7:8b].

Function
REQ-018 SHALL update mem[a] byte b at a rising edge if any port p has we[p]=1, waddr[p]=a and wbe[p][b]=1.
REQ-019 SHALL take each byte from the highest-index qualifying write port when several ports write the same byte of the same address in one cycle.
REQ-020 SHALL set valid[a]=1 for every address written with we[p]=1, even if wbe[p]=0.
REQ-021 SHALL clear every valid bit when clear=1; in the same cycle, writes apply after the clear, so written entries end valid.
REQ-022 SHALL compute the lookup value for port i as mem[raddr[i]] and valid[raddr[i]] when BYPASS_EN=0.
REQ-023 SHALL compute the lookup value for port i as the byte-merged result of REQ-018/019 applied to mem[raddr[i]] when BYPASS_EN=1; valid is forced to 1 if any write hits raddr[i], and clear in the same cycle is ignored for that lookup.
REQ-024 SHALL drive rdata[i] and rvalid[i] combinationally from the lookup when READ_LATENCY=0 and re[i]=1, and drive 0 when re[i]=0.
REQ-025 SHALL register the lookup at the edge where re[i]=1 when READ_LATENCY=1, presenting it the following cycle; re[i]=0 registers zeros.
REQ-026 SHALL, with READ_LATENCY=1 and BYPASS_EN=0, return pre-write data on a same-cycle read/write collision, and post-write data with BYPASS_EN=1.
REQ-027 SHALL give each read port independent and concurrent behaviour; several ports may read the same address.
REQ-028 SHALL ignore addresses >= DEPTH when DEPTH is not a power of 2: such writes have no effect, and such reads return rdata=0, rvalid=0.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, zero all memory words, all valid bits and all registered rdata/rvalid; reset overrides clear and we.
REQ-030 SHALL drive rdata=0 and rvalid=0 in the cycle after reset deasserts, whether READ_LATENCY=1 or READ_LATENCY=0 with re=0.
REQ-031 SHALL abandon a write presented in the same cycle as reset; the memory remains zero.

Verification
REQ-032 SHALL cover the scenario: defaults; write port0 addr 5 data 0xAABBCCDD wbe 4'hF, read addr 5 next cycle -> rdata 0xAABBCCDD, rvalid 1.
REQ-033 SHALL cover the scenario: port0 writes addr 3 0x11111111 wbe 4'hF and port1 writes addr 3 0x22222222 wbe 4'h3 in the same cycle -> subsequent read 0x11112222.
REQ-034 SHALL cover the scenario: BYPASS_EN=1, READ_LATENCY=0; mem[7]=0x0, write addr 7 0x12345678 wbe 4'h1 while reading 7 -> same-cycle rdata 0x00000078, rvalid 1.
REQ-035 SHALL cover the scenario: READ_LATENCY=1, BYPASS_EN=0; mem[2]=0xA, write addr 2 0xB while reading 2 -> next cycle rdata 0xA; repeating the read returns 0xB.
REQ-036 SHALL cover the scenario: write addrs 1 and 4, then clear together with a write to addr 4 -> read 1 gives rvalid 0 with data intact; read 4 gives rvalid 1.
REQ-037 SHALL cover the scenario: reset asserted mid-stream with a concurrent write to addr 9 -> all reads return 0 with rvalid 0 after reset.
